vram_arbiter: RTL and testbench

- Shares the single-port 8 KB video RAM between the VGA fetch path and the CPU bus.
- The VGA generator fetches one byte per 16-pixel slot and must see fixed read latency; CPU accesses fill the remaining RAM cycles.
- Sits between the vga block's address/data pins, the CPU address decoder, and the synchronous video RAM (1-cycle read latency).

---
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM arbiter: fixed-latency VGA fetch, CPU fills idle slots
module vram_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vga_req,
  input  logic [ADDR_W-1:0]  vga_addr,
  output logic [DATA_W-1:0]  vga_data,
  output logic               vga_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_ack,
  output logic [STALL_W-1:0] cpu_stall_cnt,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, ACK} cpu_state_e;

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  cpu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic               ram_we_q, ram_we_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               vga_p1_q, vga_p1_d;
  logic               vga_p2_q, vga_p2_d;
  logic               vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0]  vga_data_q, vga_data_d;
  logic               cpu_issue;

  always_comb begin
    cpu_issue   = !vga_req && cpu_req && (state_q == IDLE);
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    stall_d     = stall_q;
    // VGA pipeline never stalls: issue, RAM read, capture
    vga_p1_d    = vga_req;
    vga_p2_d    = vga_p1_q;
    vga_valid_d = vga_p2_q;
    vga_data_d  = vga_p2_q ? ram_rdata : vga_data_q;

    if (vga_req) begin
      ram_addr_d = vga_addr;
    end else if (cpu_issue) begin
      ram_addr_d  = cpu_addr;
      ram_we_d    = cpu_we;
      ram_wdata_d = cpu_wdata;
    end

    case (state_q)
      IDLE: begin
        if (cpu_issue) begin
          stall_d   = '0;
          state_d   = cpu_we ? ACK : RD1;
          cpu_ack_d = cpu_we;
        end else if (cpu_req && stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      RD1: state_d = RD2;
      RD2: begin
        state_d     = ACK;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = ram_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      stall_q     <= '0;
      vga_p1_q    <= 1'b0;
      vga_p2_q    <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      stall_q     <= stall_d;
      vga_p1_q    <= vga_p1_d;
      vga_p2_q    <= vga_p2_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q  <= vga_data_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_we        = ram_we_q;
  assign ram_wdata     = ram_wdata_q;
  assign cpu_ack       = cpu_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_stall_cnt = stall_q;
  assign vga_valid     = vga_valid_q;
  assign vga_data      = vga_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a transaction-level reference model
module tb_vram_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int N  = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [7:0]    cpu_stall_cnt;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(8)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall_cnt(cpu_stall_cnt),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous write-first video RAM
  logic [7:0] ram [0:8191];
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] = ram_wdata;
      ram_rdata <= ram_wdata;
    end else begin
      ram_rdata <= ram[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: transactions scheduled into per-cycle expectation tables
  logic [7:0]    ref_mem [0:8191];
  int            cyc = 0;
  bit            exp_vv   [N];
  logic [7:0]    exp_vd   [N];
  bit            exp_ack  [N];
  bit            exp_isrd [N];
  logic [7:0]    exp_rd   [N];
  logic [AW-1:0] e_ram_addr;
  bit            e_ram_we;
  logic [7:0]    e_ram_wdata;
  logic [7:0]    e_rdata;
  int            e_stall;
  int            m_free;
  bit            m_ack_prev;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_vv[i] = 0; exp_ack[i] = 0; exp_isrd[i] = 0; exp_vd[i] = '0; exp_rd[i] = '0;
    end
    e_ram_addr = '0; e_ram_we = 0; e_ram_wdata = '0; e_rdata = '0;
    e_stall = 0; m_free = 0; m_ack_prev = 0;
  endtask

  task automatic model_step();
    int  c;
    bit  idle;
    bit  cpu_issue;
    if (!reset) return;
    c = cyc;
    idle = (c >= m_free);
    cpu_issue = !vga_req && cpu_req && idle;
    m_ack_prev = exp_ack[c];
    e_ram_we = 0;
    if (vga_req) begin
      e_ram_addr = vga_addr;
      exp_vv[c+3] = 1;
      exp_vd[c+3] = ref_mem[vga_addr];
    end else if (cpu_issue) begin
      e_ram_addr = cpu_addr;
      e_ram_we = cpu_we;
      e_ram_wdata = cpu_wdata;
      if (cpu_we) begin
        ref_mem[cpu_addr] = cpu_wdata;
        exp_ack[c+1] = 1;
        m_free = c + 2;
      end else begin
        exp_ack[c+3] = 1;
        exp_isrd[c+3] = 1;
        exp_rd[c+3] = ref_mem[cpu_addr];
        m_free = c + 4;
      end
    end
    if (cpu_issue) e_stall = 0;
    else if (cpu_req && idle && e_stall < 255) e_stall++;
    cyc = c + 1;
    if (exp_ack[cyc] && exp_isrd[cyc]) e_rdata = exp_rd[cyc];
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("vga_valid", vga_valid, exp_vv[cyc]);
      if (exp_vv[cyc]) chk("vga_data", vga_data, exp_vd[cyc]);
      chk("cpu_ack", cpu_ack, exp_ack[cyc]);
      chk("cpu_rdata", cpu_rdata, e_rdata);
      chk("cpu_stall_cnt", cpu_stall_cnt, e_stall);
      chk("ram_we", ram_we, e_ram_we);
      chk("ram_addr", ram_addr, e_ram_addr);
      if (e_ram_we) chk("ram_wdata", ram_wdata, e_ram_wdata);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, " vga_valid"}, vga_valid, 0);
    chk({tag, " vga_data"}, vga_data, 0);
    chk({tag, " cpu_ack"}, cpu_ack, 0);
    chk({tag, " cpu_rdata"}, cpu_rdata, 0);
    chk({tag, " stall"}, cpu_stall_cnt, 0);
    chk({tag, " ram_addr"}, ram_addr, 0);
    chk({tag, " ram_we"}, ram_we, 0);
    chk({tag, " ram_wdata"}, ram_wdata, 0);
  endtask

  initial begin
    bit pending;
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 8'((i * 7 + 3) & 255);
      ref_mem[i] = 8'((i * 7 + 3) & 255);
    end
    ram[13'h0123] = 8'h5A;
    ref_mem[13'h0123] = 8'h5A;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 reset = 1'b1;

    // VGA fetch of 0x0123
    step();
    vga_req = 1; vga_addr = 13'h0123;
    step();
    vga_req = 0;
    @(negedge clk);
    chk("vga ram_addr c1", ram_addr, 13'h0123);
    chk("vga ram_we c1", ram_we, 0);
    step();
    @(negedge clk);
    chk("vga_valid c2", vga_valid, 0);
    step();
    @(negedge clk);
    chk("vga_valid c3", vga_valid, 1);
    chk("vga_data c3", vga_data, 8'h5A);
    step();

    // CPU write 0x3C to 0x1F00 then read it back
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1F00; cpu_wdata = 8'h3C;
    step();
    @(negedge clk);
    chk("wr ram_we", ram_we, 1);
    chk("wr ram_addr", ram_addr, 13'h1F00);
    chk("wr ram_wdata", ram_wdata, 8'h3C);
    chk("wr ack", cpu_ack, 1);
    cpu_req = 0;
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h1F00; cpu_wdata = 8'h00;
    step();
    @(negedge clk);
    chk("rd ack c1", cpu_ack, 0);
    step();
    step();
    @(negedge clk);
    chk("rd ack c3", cpu_ack, 1);
    chk("rd data", cpu_rdata, 8'h3C);
    cpu_req = 0;
    step();

    // Simultaneous VGA and CPU read for two cycles
    vga_req = 1; vga_addr = 13'h0200;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0040;
    step();
    vga_addr = 13'h0201;
    @(negedge clk);
    chk("sim stall 1", cpu_stall_cnt, 1);
    step();
    vga_req = 0;
    @(negedge clk);
    chk("sim stall 2", cpu_stall_cnt, 2);
    step();
    @(negedge clk);
    chk("sim stall clr", cpu_stall_cnt, 0);
    chk("sim ram_addr", ram_addr, 13'h0040);
    step();
    step();
    @(negedge clk);
    chk("sim ack", cpu_ack, 1);
    chk("sim rdata", cpu_rdata, 8'hC3);
    cpu_req = 0;
    step();

    // VGA pulse while CPU read sits in RD1
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0020;
    step();
    vga_req = 1; vga_addr = 13'h0030;
    step();
    vga_req = 0;
    @(negedge clk);
    chk("rd1 vga ram_addr", ram_addr, 13'h0030);
    step();
    @(negedge clk);
    chk("rd1 cpu ack", cpu_ack, 1);
    chk("rd1 cpu rdata", cpu_rdata, 8'hE3);
    cpu_req = 0;
    step();
    @(negedge clk);
    chk("rd1 vga_valid", vga_valid, 1);
    chk("rd1 vga_data", vga_data, 8'h53);
    step();

    // Continuous VGA traffic starves a held CPU request
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0005;
    for (int i = 0; i < 300; i++) begin
      vga_req = 1; vga_addr = AW'($urandom_range(0, 8191));
      step();
    end
    @(negedge clk);
    chk("stall saturate", cpu_stall_cnt, 255);
    vga_req = 0;
    step();
    step();
    step();
    @(negedge clk);
    chk("starved ack", cpu_ack, 1);
    chk("starved rdata", cpu_rdata, 8'h26);
    cpu_req = 0;
    step();

    // Reset during RD2, request held through reset
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0010;
    step();
    step();
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("async rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst no ack", cpu_ack, 0);
    end
    #2 reset = 1'b1;
    step();
    step();
    step();
    @(negedge clk);
    chk("rst reissue ack", cpu_ack, 1);
    chk("rst reissue rdata", cpu_rdata, 8'h73);
    cpu_req = 0;
    step();

    // Randomized traffic over a small address window to provoke hazards
    pending = 0;
    for (int i = 0; i < 1500; i++) begin
      if (pending && m_ack_prev) pending = 0;
      if (!pending) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1;
          cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = AW'($urandom_range(0, 15));
          cpu_wdata = 8'($urandom_range(0, 255));
          pending = 1;
        end else begin
          cpu_req = 0;
        end
      end
      vga_req = ($urandom_range(0, 2) == 0);
      vga_addr = AW'($urandom_range(0, 15));
      step();
    end
    vga_req = 0;
    cpu_req = 0;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
